// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the inverse cipher.
package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEXP,
        S_READY,
        S_ROUND,
        S_DONE
    } state_t;

    // Indexed directly by the round-key number being produced (1..10).
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as b^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, sq);
            sq = gmul(sq, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] a;
        a = gf_inv(b);
        return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] st_o
);

    logic [127:0] added;
    logic [127:0] mixed;

    // Byte index is row + 4*column, byte 0 in the top bits.
    always_comb begin
        added = '0;
        mixed = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                added[127 - 8*(r + 4*c) -: 8] =
                    inv_sbox(st_i[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]) ^
                    rk_i[127 - 8*(r + 4*c) -: 8];
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                mixed[127 - 8*(r + 4*c) -: 8] =
                    gmul(added[127 - 8*(r + 4*c) -: 8], 8'h0e) ^
                    gmul(added[127 - 8*((r + 1) % 4 + 4*c) -: 8], 8'h0b) ^
                    gmul(added[127 - 8*((r + 2) % 4 + 4*c) -: 8], 8'h0d) ^
                    gmul(added[127 - 8*((r + 3) % 4 + 4*c) -: 8], 8'h09);
            end
        end
        st_o = last_i ? added : mixed;
    end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key once into an 11-entry store,
// then runs one inverse round per clock behind valid/ready handshakes.
module aes128_decrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key,
    input  logic         key_load,
    output logic         key_ready,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    state_t       state_q, state_d;
    logic [3:0]   kcnt_q, kcnt_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q [0:10];

    logic         rk_we;
    logic [3:0]   rk_widx;
    logic [127:0] rk_wdata;
    logic [3:0]   prev_idx;
    logic [127:0] prev;
    logic [31:0]  temp, n0, n1, n2, n3;
    logic [127:0] key_next;
    logic [127:0] round_out;

    // Key-schedule step: derive rk[kcnt] from rk[kcnt-1].
    always_comb begin
        prev_idx = (kcnt_q == 4'd0) ? 4'd0 : kcnt_q - 4'd1;
        prev     = rk_q[prev_idx];
        temp     = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])}
                   ^ {RCON[kcnt_q], 24'h000000};
        n0       = prev[127:96] ^ temp;
        n1       = prev[95:64] ^ n0;
        n2       = prev[63:32] ^ n1;
        n3       = prev[31:0] ^ n2;
        key_next = {n0, n1, n2, n3};
    end

    aes_inv_round u_round (
        .st_i   (st_q),
        .rk_i   (rk_q[rnd_q]),
        .last_i (rnd_q == 4'd0),
        .st_o   (round_out)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        kcnt_d    = kcnt_q;
        rnd_d     = rnd_q;
        st_d      = st_q;
        rk_we     = 1'b0;
        rk_widx   = kcnt_q;
        rk_wdata  = key_next;
        key_ready = (state_q == S_IDLE) || (state_q == S_READY);
        in_ready  = (state_q == S_READY) && !key_load;
        out_valid = (state_q == S_DONE);
        out_data  = (state_q == S_DONE) ? st_q : '0;
        case (state_q)
            S_IDLE, S_READY: begin
                if (key_load) begin
                    state_d  = S_KEXP;
                    kcnt_d   = 4'd1;
                    rk_we    = 1'b1;
                    rk_widx  = 4'd0;
                    rk_wdata = key;
                end else if (state_q == S_READY && in_valid) begin
                    state_d = S_ROUND;
                    st_d    = in_data ^ rk_q[10];
                    rnd_d   = 4'd9;
                end
            end
            S_KEXP: begin
                rk_we = 1'b1;
                if (kcnt_q == 4'd10) state_d = S_READY;
                else                 kcnt_d  = kcnt_q + 4'd1;
            end
            S_ROUND: begin
                st_d = round_out;
                if (rnd_q == 4'd0) state_d = S_DONE;
                else               rnd_d   = rnd_q - 4'd1;
            end
            S_DONE: begin
                if (out_ready) state_d = S_READY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Counters, cipher state and round-key store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kcnt_q <= '0;
            rnd_q  <= '0;
            st_q   <= '0;
            for (int unsigned i = 0; i < 11; i++) rk_q[i] <= '0;
        end else begin
            kcnt_q <= kcnt_d;
            rnd_q  <= rnd_d;
            st_q   <= st_d;
            for (int unsigned i = 0; i < 11; i++) begin
                if (rk_we && rk_widx == 4'(i)) rk_q[i] <= rk_wdata;
            end
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
module tb_aes128_decrypt_iter;

    localparam logic [127:0] C1K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1P  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BRK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] BC   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] BP   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key = '0;
    logic         key_load = 1'b0;
    logic         key_ready;
    logic [127:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         rnd_or = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes128_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .key_load  (key_load),
        .key_ready (key_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference AES (byte arrays, tables built by generator walk)
    logic [7:0] sb [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] p = 8'h01;
        logic [7:0] q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ 8'(q << 1);
            q = q ^ 8'(q << 2);
            q = q ^ 8'(q << 4);
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
        end
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [7:0] bget(input logic [127:0] x, input int i);
        return x[127 - 8*i -: 8];
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] k, input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk;
        logic [127:0] res;
        rk = round_key(k, 10);
        for (int i = 0; i < 16; i++) s[i] = bget(ct, i) ^ bget(rk, i);
        for (int rr = 9; rr >= 0; rr--) begin
            rk = round_key(k, rr);
            for (int col = 0; col < 4; col++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*col] = isb[s[r + 4*((col - r + 4) % 4)]] ^ bget(rk, r + 4*col);
            for (int col = 0; col < 4; col++)
                for (int r = 0; r < 4; r++)
                    s[r + 4*col] = (rr == 0) ? t[r + 4*col] :
                        mul(t[4*col + r], 8'h0e) ^ mul(t[4*col + (r+1)%4], 8'h0b) ^
                        mul(t[4*col + (r+2)%4], 8'h0d) ^ mul(t[4*col + (r+3)%4], 8'h09);
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- transaction-level model: latencies and expected plaintext
    logic         m_haskey, m_done;
    int           m_kleft, m_bleft;
    logic [127:0] m_key, m_expd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_haskey <= 1'b0;
            m_done   <= 1'b0;
            m_kleft  <= 0;
            m_bleft  <= 0;
            m_expd   <= '0;
            m_key    <= '0;
        end else if (m_kleft > 0) begin
            m_kleft <= m_kleft - 1;
            if (m_kleft == 1) m_haskey <= 1'b1;
        end else if (m_bleft > 0) begin
            m_bleft <= m_bleft - 1;
            if (m_bleft == 1) m_done <= 1'b1;
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (key_load) begin
            m_kleft  <= 10;
            m_haskey <= 1'b0;
            m_key    <= key;
        end else if (m_haskey && in_valid) begin
            m_bleft <= 10;
            m_expd  <= ref_decrypt(m_key, in_data);
        end
    end

    // Per-cycle comparison of all handshake outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_kr;
            exp_kr = (m_kleft == 0) && (m_bleft == 0) && !m_done;
            check("key_ready", {127'b0, key_ready}, {127'b0, exp_kr});
            check("in_ready", {127'b0, in_ready}, {127'b0, exp_kr && m_haskey && !key_load});
            check("out_valid", {127'b0, out_valid}, {127'b0, m_done});
            if (m_done) check("out_data", out_data, m_expd);
        end
    end

    always @(posedge clk) begin
        if (rnd_or) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus helpers
    // which: 0 in_ready, 1 out_valid, 2 key_ready. Returns at the negedge where seen.
    task automatic wait_for(input int which, input string name);
        logic seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            seen = (which == 0) ? in_ready : (which == 1) ? out_valid : key_ready;
        end
        if (!seen) check({"timeout_", name}, 128'd0, 128'd1);
    endtask

    task automatic load_key(input logic [127:0] k, output int kc);
        wait_for(2, "key_ready");
        @(posedge clk); #1;
        key = k;
        key_load = 1'b1;
        @(posedge clk); #1;
        kc = cyc;
        key_load = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, output int acc);
        in_valid = 1'b1;
        in_data  = d;
        wait_for(0, "in_ready");
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kc, a1, a2, r;
        build_tables();
        check("model_c1", ref_decrypt(C1K, C1C), C1P);
        check("model_b_rk10", round_key(BK, 10), BRK);
        check("model_b", ref_decrypt(BK, BC), BP);

        #2;
        check("rst_key_ready", {127'b0, key_ready}, 128'd1);
        check("rst_in_ready", {127'b0, in_ready}, 128'd0);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        #10 rst_n = 1'b1;

        // FIPS-197 C.1 with backpressure on the result
        load_key(C1K, kc);
        wait_for(0, "kexp_done");
        check("kexp_latency", 128'(cyc - kc), 128'd10);
        @(posedge clk); #1;
        send(C1C, a1);
        wait_for(1, "c1_out");
        check("c1_latency", 128'(cyc - a1), 128'd10);
        check("c1_data", out_data, C1P);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_data", out_data, C1P);
            check("bp_in_ready", {127'b0, in_ready}, 128'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_in_ready", {127'b0, in_ready}, 128'd1);
        check("release_out_valid", {127'b0, out_valid}, 128'd0);

        // two back-to-back blocks under the same key
        @(posedge clk); #1;
        send(C1C, a1);
        send(C1C, a2);
        check("b2b_gap", 128'(a2 - a1), 128'd12);
        wait_for(1, "b2b_out");
        check("b2b_data", out_data, C1P);

        // FIPS-197 Appendix B
        load_key(BK, kc);
        wait_for(0, "b_kexp");
        check("b_rk10", dut.rk_q[10], BRK);
        @(posedge clk); #1;
        send(BC, a1);
        wait_for(1, "b_out");
        check("b_data", out_data, BP);

        // key_load and in_valid together in READY: key wins, block waits
        wait_for(2, "prio_ready");
        @(posedge clk); #1;
        key = C1K;
        key_load = 1'b1;
        in_valid = 1'b1;
        in_data = C1C;
        @(posedge clk); #1;
        kc = cyc;
        key_load = 1'b0;
        send(C1C, a1);
        check("prio_accept_edge", 128'(a1 - kc), 128'd11);
        wait_for(1, "prio_out");
        check("prio_data", out_data, C1P);

        // reset during the fifth round cycle
        @(posedge clk); #1;
        send(128'({$urandom, $urandom, $urandom, $urandom}), a1);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {127'b0, out_valid}, 128'd0);
        check("midrst_in_ready", {127'b0, in_ready}, 128'd0);
        check("midrst_key_ready", {127'b0, key_ready}, 128'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("postrst_in_ready", {127'b0, in_ready}, 128'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        load_key(BK, kc);
        send(BC, a1);
        wait_for(1, "postrst_out");
        check("postrst_data", out_data, BP);

        // randomized traffic, random keys and random sink stalls
        rnd_or = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0)
                load_key(128'({$urandom, $urandom, $urandom, $urandom}), kc);
            send(128'({$urandom, $urandom, $urandom, $urandom}), a1);
            r = $urandom_range(0, 3);
            repeat (r) @(posedge clk);
            #1;
        end
        wait_for(1, "rand_last_out");
        @(posedge clk);
        rnd_or = 1'b0;
        #2 out_ready = 1'b1;
        wait_for(2, "rand_drain");
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes128_decrypt_iter.md
# aes128_decrypt_iter

Iterative AES-128 inverse cipher (FIPS-197 §5.3), the decryption counterpart to the team's combinational AES-128 encryption core. It expands a loaded key once into an on-chip round-key store, then decrypts one 128-bit block at a time, one round per clock, behind valid/ready handshakes. It is the receive-side block that turns ciphertext from the encryption path back into plaintext.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10.
- clk  in  1  sole clock; every register is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- key  in  128  cipher key; byte 0 = key[127:120].
- key_load  in  1  key-load request; sampled only when key_ready=1.
- key_ready  out  1  high in IDLE and READY.
- in_data  in  128  ciphertext block; byte 0 = [127:120], column-major state.
- in_valid  in  1  ciphertext valid.
- in_ready  out  1  = (state==READY) && !key_load.
- out_data  out  128  plaintext; held stable while out_valid=1.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  sink accepts plaintext.

## Operation
- FSM states: IDLE (no key), KEXP, READY, ROUND, DONE.
- Transitions:
  - IDLE/READY + key_load -> KEXP; rk[0] <= key, kcnt <= 1.
  - KEXP -> READY after rk[10] is written.
  - READY + in_valid && in_ready -> ROUND; st <= in_data ^ rk[10], rnd <= 9.
  - ROUND -> DONE after the rnd=0 update.
  - DONE + out_ready -> READY.
- KEXP: each cycle writes rk[kcnt] from rk[kcnt-1] using the FIPS-197 schedule (RotWord, SubWord, Rcon[kcnt] on word 0, XOR chain on words 1-3), then kcnt++.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36.
- ROUND, rnd 9..1: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[rnd]).
- ROUND, rnd 0: st <= InvSubBytes(InvShiftRows(st)) ^ rk[0]; no InvMixColumns.
- out_data = st in DONE.
- Key priority: key_load in READY with in_valid high starts KEXP and does not accept the block.
- In ROUND and DONE: key_load is ignored and rk is not modified.
- Once expanded, the key remains valid across any number of blocks until the next key_load or reset.
- in_valid in IDLE or KEXP is never accepted; the source must hold it.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, kcnt=0, rnd=0, st=0, rk[*]=0.
  - out_valid=0, out_data=0, in_ready=0, key_ready=1.
- Key expansion: key_load accepted at edge K.
  - key_ready=0 and in_ready=0 from K through K+10.
  - READY after edge K+10; in_ready can rise in the following cycle.
- Decrypt: block accepted at edge T; 10 ROUND cycles (edges T+1..T+10).
  - out_valid=1 after edge T+10, i.e. 10-cycle latency.
- DONE holds out_valid and out_data until out_ready=1.
  - Handshake at edge D -> READY; in_ready=1 after D.
  - No overlap: best-case throughput is 1 block per 12 cycles with out_ready tied high.
- Reset mid-KEXP/ROUND/DONE: the block and key are discarded; a new key_load is required.
- out_ready is ignored outside DONE.

## Structure
- Package aes_pkg:
  - functions sbox(byte), inv_sbox(byte), xtime(byte), gmul(byte, coeff) for 9, b, d, e;
  - Rcon constant array;
  - FSM state enum typedef.
- Sub-module aes_inv_round: combinational; inputs st, rk, last flag; output is the next state.
  - This is the only per-round datapath instance.
- Key-step logic and the 11×128 rk register file stay in the top module.

## Test plan
- FIPS-197 C.1:
  - key=000102030405060708090a0b0c0d0e0f, in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff.
  - out_valid exactly 10 cycles after acceptance.
- FIPS-197 App. B:
  - key=2b7e151628aed2a6abf7158809cf4f3c; rk[10] must equal d014f9a8c9ee2589e13f0cc8b6630ca6.
  - in_data=3925841d02dc09fbdc118597196a0b32 -> out_data=3243f6a8885a308d313198a2e0370734.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after C.1 completes -> out_data stable, in_ready=0 throughout.
  - Release out_ready -> in_ready=1 next cycle.
- Two consecutive C.1 blocks without reloading the key -> both decrypt correctly; gap between acceptances is 12 cycles.
- In READY, assert key_load and in_valid together:
  - the block is not accepted and KEXP starts;
  - the block is accepted after edge K+10 and decrypts under the new key.
- Assert rst_n low in ROUND cycle 5 -> out_valid=0 immediately, state IDLE, in_ready=0 until a new key load completes.
